// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared constants and types for the nn_sample_sequencer slice.
//   DATA_W  - feature / result word width
//   NUM_IN  - network inputs per sample (x1..x6)
//   NUM_OUT - network outputs per sample (y1..y3)
//   IDX_W   - staging write-index width
//   seq_state_e - engine FSM encoding
package nn_seq_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_IN  = 6;
  localparam int unsigned NUM_OUT = 3;
  localparam int unsigned IDX_W   = $clog2(NUM_IN);

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/nn_sample_sequencer_if.sv
// nn_sample_sequencer_if: every non-clock signal of the sequencer.
//   in_*  : valid/ready feature-word stream into the staging buffer
//   nn_*  : start/done handshake and x/y buses of the Neural_network
//   out_* : valid/ready result slot with sequence tag
//   busy / timeout_err : status
// modport master = sequencer side, modport slave = environment side.
interface nn_sample_sequencer_if #(
  parameter int unsigned SEQ_W = 8
);
  import nn_seq_pkg::*;

  logic             in_valid_x70;
  logic             in_ready_x70;
  word_t            in_data_x70;
  logic             nn_start_x70;
  logic             nn_done_x70;
  word_t            nn_x1_x70, nn_x2_x70, nn_x3_x70;
  word_t            nn_x4_x70, nn_x5_x70, nn_x6_x70;
  word_t            nn_y1_x70, nn_y2_x70, nn_y3_x70;
  logic             out_valid_x70;
  logic             out_ready_x70;
  word_t            out_y1_x70, out_y2_x70, out_y3_x70;
  logic [SEQ_W-1:0] out_seq_x70;
  logic             busy_x70;
  logic             timeout_err_x70;

  modport master (
    input  in_valid_x70, in_data_x70, nn_done_x70,
           nn_y1_x70, nn_y2_x70, nn_y3_x70, out_ready_x70,
    output in_ready_x70, nn_start_x70,
           nn_x1_x70, nn_x2_x70, nn_x3_x70, nn_x4_x70, nn_x5_x70, nn_x6_x70,
           out_valid_x70, out_y1_x70, out_y2_x70, out_y3_x70, out_seq_x70,
           busy_x70, timeout_err_x70
  );

  modport slave (
    output in_valid_x70, in_data_x70, nn_done_x70,
           nn_y1_x70, nn_y2_x70, nn_y3_x70, out_ready_x70,
    input  in_ready_x70, nn_start_x70,
           nn_x1_x70, nn_x2_x70, nn_x3_x70, nn_x4_x70, nn_x5_x70, nn_x6_x70,
           out_valid_x70, out_y1_x70, out_y2_x70, out_y3_x70, out_seq_x70,
           busy_x70, timeout_err_x70
  );

endinterface

// File: rtl/nn_seq_stage_buf.sv
// nn_seq_stage_buf: 6 x 32-bit staging buffer for one network sample.
//   clk_i, rst_i   - clock, async active-high reset
//   in_valid_i     - word valid; in_ready_o = buffer not full
//   in_data_i      - word, written to slot[idx] in x1..x6 order
//   clr_i          - engine has copied the sample out; reopen the buffer
//   full_o         - six words held
//   slot_o         - staged words, slot_o[0] = x1
module nn_seq_stage_buf
  import nn_seq_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  input  word_t                          in_data_i,
  input  logic                           clr_i,
  output logic                           in_ready_o,
  output logic                           full_o,
  output logic [NUM_IN-1:0][DATA_W-1:0]  slot_o
);

  logic [IDX_W-1:0]               idx_q;
  logic                           full_q;
  logic [NUM_IN-1:0][DATA_W-1:0]  slot_q;
  logic                           accept_s;

  assign accept_s   = in_valid_i & ~full_q;
  assign in_ready_o = ~full_q;
  assign full_o     = full_q;
  assign slot_o     = slot_q;

  // Fill slots in order; the sixth word wraps the index and closes the buffer.
  // A clear can only arrive while full, so it never races an accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      slot_q <= '0;
    end else begin
      if (accept_s) begin
        slot_q[idx_q] <= in_data_i;
        if (idx_q == IDX_W'(NUM_IN - 1)) begin
          idx_q  <= '0;
          full_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end else if (clr_i) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nn_sample_sequencer.sv
// nn_sample_sequencer: front-end that packs six feature words into a sample,
// launches the Neural_network, and captures its three results with a tag.
//   clk_x70, reset_x70 - clock, async active-high reset
//   bus (master)       - stream in, network handshake/buses, result slot, status
// Parameters: SEQ_W (tag width), START_PULSE (1..15 start cycles),
//   TIMEOUT_CYC (WAIT watchdog limit).
// Optional build macro NN_SEQ_TIMEOUT_EN: enables the WAIT watchdog and the
// sticky timeout_err; without it timeout_err is 0 and WAIT never expires.
module nn_sample_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned SEQ_W       = 8,
  parameter int unsigned START_PULSE = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                  clk_x70,
  input  logic                  reset_x70,
  nn_sample_sequencer_if.master bus
);

  localparam int unsigned PULSE_W = 4;

  logic [NUM_IN-1:0][DATA_W-1:0]  stage_s;
  logic                           stage_full_s;
  logic                           stage_ready_s;
  logic                           launch_s;
  logic                           done_rise_s;
  logic                           wd_expire_s;

  seq_state_e                     state_q;
  logic [NUM_IN-1:0][DATA_W-1:0]  nn_x_q;
  logic [NUM_OUT-1:0][DATA_W-1:0] out_y_q;
  logic [SEQ_W-1:0]               seq_q;
  logic [SEQ_W-1:0]               seq_d;
  logic [SEQ_W-1:0]               out_seq_q;
  logic [PULSE_W-1:0]             pulse_cnt_q;
  logic                           nn_start_q;
  logic                           out_valid_q;
  logic                           busy_q;
  logic                           done_prev_q;
  logic                           timeout_err_s;

  // The result slot is free if empty or being drained this cycle; launching
  // only then guarantees the slot is empty when the network finishes.
  assign launch_s    = (state_q == ST_IDLE) & stage_full_s &
                       (~out_valid_q | bus.out_ready_x70);
  assign done_rise_s = bus.nn_done_x70 & ~done_prev_q;
  assign seq_d       = seq_q + SEQ_W'(1);

  nn_seq_stage_buf u_stage (
    .clk_i      (clk_x70),
    .rst_i      (reset_x70),
    .in_valid_i (bus.in_valid_x70),
    .in_data_i  (bus.in_data_x70),
    .clr_i      (launch_s),
    .in_ready_o (stage_ready_s),
    .full_o     (stage_full_s),
    .slot_o     (stage_s)
  );

`ifdef NN_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wait_cnt_q;
  logic            timeout_err_q;

  assign wd_expire_s   = (wait_cnt_q == WD_W'(TIMEOUT_CYC - 1)) & ~done_rise_s;
  assign timeout_err_s = timeout_err_q;

  // Count WAIT cycles of the current sample; the error flag is sticky.
  always_ff @(posedge clk_x70 or posedge reset_x70) begin
    if (reset_x70) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + WD_W'(1);
      if (wd_expire_s) begin
        timeout_err_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end
`else
  assign wd_expire_s   = 1'b0;
  assign timeout_err_s = 1'b0;
`endif

  // Engine FSM with registered outputs. The sample is copied to the network
  // inputs on the IDLE->LOAD edge so x1..x6 are already valid during LOAD.
  always_ff @(posedge clk_x70 or posedge reset_x70) begin
    if (reset_x70) begin
      state_q     <= ST_IDLE;
      nn_x_q      <= '0;
      out_y_q     <= '0;
      seq_q       <= '0;
      out_seq_q   <= '0;
      pulse_cnt_q <= '0;
      nn_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_prev_q <= 1'b1;
    end else begin
      done_prev_q <= bus.nn_done_x70;
      if (out_valid_q && bus.out_ready_x70) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (launch_s) begin
            nn_x_q  <= stage_s;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          nn_start_q  <= 1'b1;
          pulse_cnt_q <= '0;
          state_q     <= ST_START;
        end
        ST_START: begin
          if (pulse_cnt_q == PULSE_W'(START_PULSE - 1)) begin
            nn_start_q <= 1'b0;
            state_q    <= ST_WAIT;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + PULSE_W'(1);
          end
        end
        ST_WAIT: begin
          if (done_rise_s) begin
            out_y_q     <= {bus.nn_y3_x70, bus.nn_y2_x70, bus.nn_y1_x70};
            out_seq_q   <= seq_q;
            out_valid_q <= 1'b1;
            seq_q       <= seq_d;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (wd_expire_s) begin
            // Sample dropped, but its tag is consumed.
            seq_q   <= seq_d;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          nn_start_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_x70    = stage_ready_s;
  assign bus.nn_start_x70    = nn_start_q;
  assign bus.nn_x1_x70       = nn_x_q[0];
  assign bus.nn_x2_x70       = nn_x_q[1];
  assign bus.nn_x3_x70       = nn_x_q[2];
  assign bus.nn_x4_x70       = nn_x_q[3];
  assign bus.nn_x5_x70       = nn_x_q[4];
  assign bus.nn_x6_x70       = nn_x_q[5];
  assign bus.out_valid_x70   = out_valid_q;
  assign bus.out_y1_x70      = out_y_q[0];
  assign bus.out_y2_x70      = out_y_q[1];
  assign bus.out_y3_x70      = out_y_q[2];
  assign bus.out_seq_x70     = out_seq_q;
  assign bus.busy_x70        = busy_q;
  assign bus.timeout_err_x70 = timeout_err_s;

endmodule
